// File: rtl/serdes_deframer.sv
// Serial-to-byte deframer: hunts for a sync byte in an LSB-first bit stream,
// assembles fixed-length frames and emits them on an AXI-Stream master via a FIFO.
module serdes_deframer #(
  parameter logic [7:0] SyncWord  = 8'hD5,
  parameter int         FrameLen  = 4,
  parameter int         FifoDepth = 4
) (
  input  logic       ref_clk,
  input  logic       rst_n,
  input  logic       data_in,
  input  logic       bit_en,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       locked,
  output logic       overflow
);

  localparam int AW = $clog2(FifoDepth);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] window;
  logic       push, push_last;

  // The byte completing on this edge, including the bit currently on the wire.
  assign window = {data_in, sr_q[7:1]};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    push       = 1'b0;
    push_last  = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        HUNT: begin
          if (window == SyncWord) begin
            state_d    = LOCKED;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 8'd0;
          end
        end
        LOCKED: begin
          if (bit_cnt_q == 3'd7) begin
            push      = 1'b1;
            push_last = (byte_cnt_q == 8'(FrameLen - 1));
            bit_cnt_d = 3'd0;
            if (push_last) begin
              state_d    = HUNT;
              byte_cnt_d = 8'd0;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and the
  // sensitivity list carries only the clock.
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      sr_q       <= 8'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      if (bit_en) sr_q <= window;
    end
  end

  // Output FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [8:0]  mem [FifoDepth];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, pop, accept, overflow_q;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop    = !empty && m_axis_tready;
  assign accept = push && (!full || pop);

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and the output mux hides stale contents.
  always_ff @(posedge ref_clk) begin
    if (accept) mem[wr_ptr_q[AW-1:0]] <= {push_last, window};
  end

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign m_axis_tvalid = !empty;
  assign {m_axis_tlast, m_axis_tdata} = empty ? 9'd0 : mem[rd_ptr_q[AW-1:0]];
  assign locked   = (state_q == LOCKED);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serdes_deframer.sv
// Self-checking bench for serdes_deframer: directed scenarios plus randomized
// framed traffic, compared every cycle against a queue-based reference model.
module tb_serdes_deframer;

  localparam logic [7:0] SYNC  = 8'hD5;
  localparam int         FLEN  = 4;
  localparam int         DEPTH = 4;

  logic       ref_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_in = 1'b0;
  logic       bit_en = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic       m_axis_tlast;
  logic       locked;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  serdes_deframer #(.SyncWord(SYNC), .FrameLen(FLEN), .FifoDepth(DEPTH)) dut (
    .ref_clk      (ref_clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .bit_en       (bit_en),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .locked       (locked),
    .overflow     (overflow)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: last eight wire bits, frame progress, and the FIFO as a queue.
  typedef struct {logic [7:0] data; logic last;} beat_t;
  beat_t q[$];
  bit    hist[$];
  bit    m_locked;
  bit    m_ovf;
  int    m_nbits, m_nbytes;
  logic [7:0] m_cur;

  function automatic logic [7:0] hist_value();
    logic [7:0] v = 8'd0;
    for (int i = 0; i < 8; i++) v[i] = hist[i];
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(1'b0);
    m_locked = 1'b0;
    m_ovf    = 1'b0;
    m_nbits  = 0;
    m_nbytes = 0;
    m_cur    = 8'd0;
  endtask

  task automatic model_cycle(input bit en, input bit b, input bit rdy);
    bit    do_push = 1'b0;
    bit    do_pop;
    bit    was_full;
    beat_t nb;
    do_pop   = (q.size() > 0) && rdy;
    was_full = (q.size() == DEPTH);
    if (en) begin
      hist.push_back(b);
      void'(hist.pop_front());
      if (!m_locked) begin
        if (hist_value() == SYNC) begin
          m_locked = 1'b1;
          m_nbits  = 0;
          m_nbytes = 0;
          m_cur    = 8'd0;
        end
      end else begin
        m_cur[m_nbits] = b;
        m_nbits++;
        if (m_nbits == 8) begin
          do_push = 1'b1;
          nb.data = m_cur;
          nb.last = (m_nbytes == FLEN - 1);
          m_nbytes++;
          m_nbits = 0;
          m_cur   = 8'd0;
          if (nb.last) m_locked = 1'b0;
        end
      end
    end
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      if (was_full && !do_pop) m_ovf = 1'b1;
      else q.push_back(nb);
    end
  endtask

  // One clock: drive on the falling edge, advance the model, sample after the rise.
  task automatic step(input bit en, input bit b, input bit rdy, input bit rst);
    @(negedge ref_clk);
    rst_n = rst; bit_en = en; data_in = b; m_axis_tready = rdy;
    if (!rst) model_reset();
    else model_cycle(en, b, rdy);
    @(posedge ref_clk);
    #1;
    check("tvalid", 32'(m_axis_tvalid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("tdata", 32'(m_axis_tdata), 32'(q[0].data));
      check("tlast", 32'(m_axis_tlast), 32'(q[0].last));
    end
    if (!rst) begin
      check("rst_tdata", 32'(m_axis_tdata), 32'd0);
      check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    end
    check("locked", 32'(locked), 32'(m_locked));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  int rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random
  int gap_pct  = 0;  // chance of an idle bit_en=0 cycle before each bit

  function automatic bit pick_ready();
    if (rdy_mode == 0) return 1'b1;
    if (rdy_mode == 1) return 1'b0;
    return ($urandom_range(99) < 60);
  endfunction

  task automatic send_bit(input bit b);
    while (gap_pct > 0 && $urandom_range(99) < gap_pct)
      step(1'b0, 1'($urandom), pick_ready(), 1'b1);
    step(1'b1, b, pick_ready(), 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, pick_ready(), 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    do_reset();
    do_reset();

    // 1: basic frame of 0xAA
    rdy_mode = 0;
    send_byte(SYNC);
    for (int i = 0; i < FLEN; i++) send_byte(8'hAA);
    idle(4);

    // 2: idle zeros, bit-slipped sync after junk bits
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_byte(SYNC);
    send_byte(8'h3C);
    for (int i = 1; i < FLEN; i++) send_byte(8'(i));
    idle(4);

    // 3: downstream stalled for a frame, then overflow on the next frame
    rdy_mode = 1;
    send_byte(SYNC);
    for (int i = 0; i < FLEN; i++) send_byte(8'h10 + 8'(i));
    send_byte(SYNC);
    send_byte(8'h99);
    rdy_mode = 0;
    idle(8);
    for (int i = 1; i < FLEN; i++) send_byte(8'h20 + 8'(i));
    idle(6);

    // 4: bit_en alternating across sync and first payload byte
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, SYNC[i], 1'b1, 1'b1);
      step(1'b0, ~SYNC[i], 1'b1, 1'b1);
    end
    begin
      logic [7:0] p = 8'h5A;
      for (int i = 0; i < 8; i++) begin
        step(1'b1, p[i], 1'b1, 1'b1);
        step(1'b0, ~p[i], 1'b1, 1'b1);
      end
    end
    for (int i = 1; i < FLEN; i++) send_byte(8'h60 + 8'(i));
    idle(4);

    // 5: reset after 12 payload bits, then a fresh frame
    rdy_mode = 1;
    send_byte(SYNC);
    send_byte(8'hC3);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rdy_mode = 0;
    do_reset();
    send_byte(SYNC);
    send_byte(8'h11);
    for (int i = 1; i < FLEN; i++) send_byte(8'h70 + 8'(i));
    idle(4);

    // 6: sync pattern as payload stays data
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(SYNC);
    send_byte(SYNC);
    send_byte(8'h02);
    idle(4);

    // Randomized framed traffic with gaps, back-pressure and junk
    rdy_mode = 2;
    for (int f = 0; f < 60; f++) begin
      gap_pct = $urandom_range(40);
      for (int j = 0; j < int'($urandom_range(12)); j++) send_bit(1'($urandom));
      send_byte(SYNC);
      for (int i = 0; i < FLEN; i++)
        send_byte(($urandom_range(9) == 0) ? SYNC : 8'($urandom));
      if ($urandom_range(19) == 0) do_reset();
    end
    gap_pct  = 0;
    rdy_mode = 0;
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serdes_deframer.md
Name: serdes_deframer

Overview:
Receive-side stage directly downstream of clock_recovery. Takes the recovered serial bit stream (clock_recovery data_out) in the ref_clk domain. Hunts for a sync byte, then assembles a fixed-length frame of LSB-first bytes. Emits the bytes on an AXI-Stream master through a small output FIFO, with tlast on the final byte of each frame.

Parameters:
SyncWord, 8'hD5, frame delimiter byte, LSB-first on the wire
FrameLen, 4, data bytes per frame following SyncWord (1..255)
FifoDepth, 4, output FIFO entries (power of two, >=2)

Ports:
ref_clk  input  1  sole clock, the same phase-0 clock used by clock_recovery
rst_n  input  1  reset, synchronous, active-low
data_in  input  1  recovered serial bit (from clock_recovery data_out)
bit_en  input  1  data_in valid this cycle; bits are ignored when low
m_axis_tdata  output  8  assembled byte
m_axis_tvalid  output  1  FIFO not empty
m_axis_tready  input  1  downstream accept
m_axis_tlast  output  1  byte is last of frame
locked  output  1  high while in LOCKED state
overflow  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (rst_n low at a ref_clk edge): state=HUNT, shift register=0, bit_cnt=0, byte_cnt=0, FIFO empty. Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, locked=0, overflow=0. Reset mid-frame discards the partial byte and all FIFO contents.
- Shift: on bit_en=1, sr <= {data_in, sr[7:1]}. The first bit received lands in bit 0 after 8 shifts.
- HUNT:
  - Each bit_en cycle, compare the window {data_in, sr[7:1]} against SyncWord.
  - On match: next state LOCKED, bit_cnt=0, byte_cnt=0, locked=1 from the next cycle.
  - The sync byte itself is never written to the FIFO.
- LOCKED:
  - bit_cnt increments on each bit_en.
  - On the 8th bit (bit_cnt==7 and bit_en): the byte {data_in, sr[7:1]} is pushed into the FIFO in that same edge. tlast=1 when byte_cnt==FrameLen-1.
  - Then bit_cnt=0 and byte_cnt increments.
  - After the tlast byte: state=HUNT, locked=0 next cycle. No sync search on the bit that completed the last byte; hunting resumes on the following bit.
- bit_en low: no state, counter, or shift change.
- Latency: the byte appears at m_axis_tdata with m_axis_tvalid=1 on the cycle after the edge that sampled its 8th bit, provided the FIFO was empty.
- AXI-Stream rules:
  - tdata and tlast are stable while tvalid=1 and tready=0.
  - Pop on tvalid && tready.
  - tvalid never depends combinationally on tready.
- FIFO full on push:
  - With no pop that cycle: drop the byte and set overflow=1 (sticky until reset). Frame counting continues; a dropped tlast byte still returns the FSM to HUNT.
  - Simultaneous push and pop when full: allowed, no drop.
  - Simultaneous push and pop when empty: push lands, tvalid next cycle.
- Pointers wrap modulo FifoDepth. An extra occupancy bit distinguishes full from empty.
- Sync patterns appearing inside payload data while LOCKED are treated as data.

Test Plan:
1. Reset, then bits of 0xD5 LSB-first (1,0,1,0,1,0,1,1) followed by 0xAA ×4, bit_en=1, tready=1 -> locked rises the cycle after the 8th sync bit. Four beats of tdata=0xAA appear, tlast=1 on the 4th only. locked=0 after the frame.
2. Idle stream 0x00 bits, then a single bit-slipped sync (3 junk bits 1,1,0 then 0xD5) -> locks exactly at the end of 0xD5 with no false lock from the junk. First byte after sync is framed correctly (0x3C payload -> tdata 0x3C).
3. tready=0 for a whole frame with FrameLen=4, FifoDepth=4 -> 4 entries held, overflow=0. A second frame's first byte is dropped and overflow=1. After tready=1 the 4 original bytes drain in order with unchanged tdata.
4. bit_en toggled 1,0,1,0 across the sync and first payload byte 0x5A -> same result as continuous bit_en: tdata=0x5A, no extra or missing bits.
5. Assert rst_n=0 for one cycle after 12 payload bits -> tvalid=0, locked=0, overflow=0 next cycle. A fresh 0xD5 + 0x11 frame then yields tdata=0x11.
6. Payload byte equal to 0xD5 inside a frame -> emitted as data (tdata=0xD5), no relock or frame restart.
